// File: rtl/bus_slave_responder_if.sv
// rtl/bus_slave_responder_if.sv - asynchronous-handshake bus signal bundle
interface bus_slave_responder_if;
   logic        AS_N;
   logic        WR_N;
   logic [31:0] AO;
   logic [31:0] WDO;
   logic        ACK_N;
   logic [31:0] RDO;

   modport master (
      output AS_N,
      output WR_N,
      output AO,
      output WDO,
      input  ACK_N,
      input  RDO
   );

   modport slave (
      input  AS_N,
      input  WR_N,
      input  AO,
      input  WDO,
      output ACK_N,
      output RDO
   );
endinterface

// File: rtl/bus_slave_responder.sv
// rtl/bus_slave_responder.sv - wait-state bus target with register-array memory
module bus_slave_responder #(
   parameter int ADDR_BITS   = 4,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   bus_slave_responder_if.slave  bus,
   output logic [1:0]            state_out,
   output logic [7:0]            write_count,
   output logic                  addr_err,
   input  logic [ADDR_BITS-1:0]  peek_addr,
   output logic [31:0]           peek_data
);

   localparam int         DEPTH     = 1 << ADDR_BITS;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_ACK     = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [3:0]           wait_cnt;
   logic [3:0]           wait_cnt_nxt;
   logic                 commit;

   logic [31:0]          lat_addr;
   logic [31:0]          lat_wdata;
   logic                 lat_wr_n;

   logic [31:0]          cur_addr;
   logic [31:0]          cur_wdata;
   logic                 cur_wr_n;
   logic                 in_range;
   logic [ADDR_BITS-1:0] word_idx;

   logic [31:0]          mem [DEPTH];
   logic                 ack_n_q;
   logic [31:0]          rdo_q;

   // With zero wait states the commit happens on the strobe-sampling edge itself,
   // before the latches hold anything, so the live bus is used while in IDLE.
   always_comb begin
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      cur_wr_n  = lat_wr_n;
      if (state == ST_IDLE) begin
         cur_addr  = bus.AO;
         cur_wdata = bus.WDO;
         cur_wr_n  = bus.WR_N;
      end
   end

   assign in_range = ((cur_addr >> ADDR_BITS) == 32'd0);
   assign word_idx = cur_addr[ADDR_BITS-1:0];

   // Next-state decode; commit marks the edge that enters ACK.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      commit       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!bus.AS_N) begin
               if (WAIT_STATES == 0) begin
                  state_nxt = ST_ACK;
                  commit    = 1'b1;
               end else begin
                  state_nxt    = ST_WAIT;
                  wait_cnt_nxt = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (bus.AS_N) begin
               // master withdrew the strobe: drop the access without side effects
               state_nxt = ST_IDLE;
            end else if (wait_cnt <= 4'd1) begin
               state_nxt = ST_ACK;
               commit    = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         ST_ACK: begin
            state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            // a strobe held low stays here so it is never acknowledged twice
            if (bus.AS_N) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and wait counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Capture the request when IDLE sees the strobe; held for the whole access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         lat_wr_n  <= 1'b1;
      end else if (state == ST_IDLE && !bus.AS_N) begin
         lat_addr  <= bus.AO;
         lat_wdata <= bus.WDO;
         lat_wr_n  <= bus.WR_N;
      end
   end

   // Acknowledge is a registered decode of the ACK state; read data loads on commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_n_q <= 1'b1;
         rdo_q   <= 32'd0;
      end else begin
         ack_n_q <= (state_nxt != ST_ACK);
         if (commit && cur_wr_n) begin
            rdo_q <= in_range ? mem[word_idx] : 32'd0;
         end
      end
   end

   // Saturating write counter and sticky out-of-range flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_count <= 8'd0;
         addr_err    <= 1'b0;
      end else if (commit) begin
         if (!in_range) begin
            addr_err <= 1'b1;
         end else if (!cur_wr_n && write_count != 8'hFF) begin
            write_count <= write_count + 8'd1;
         end
      end
   end

   // Register-array memory, cleared by reset and written only by in-range commits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'd0;
         end
      end else if (commit && in_range && !cur_wr_n) begin
         mem[word_idx] <= cur_wdata;
      end
   end

   assign bus.ACK_N = ack_n_q;
   assign bus.RDO   = rdo_q;
   assign state_out = state;
   assign peek_data = mem[peek_addr];

endmodule
